// File: rtl/inv_bank_pkg.sv
// Shared constants and edge-event encoding for the deglitched inverter bank and
// the event logic downstream of it.
package inv_bank_pkg;

  localparam int N_CH_MAX = 16;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_t;

  function automatic edge_t edge_of(input logic new_s);
    return new_s ? EDGE_RISE : EDGE_FALL;
  endfunction

endpackage

// File: rtl/inv_dgl_ch.sv
// One deglitch channel: 2-flop synchroniser, stability counter, filtered state and
// registered edge pulses; filtered state moves 2+thr edges after the input is captured.
module inv_dgl_ch
  import inv_bank_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_raw,
  input  logic [CNT_W-1:0] i_thr,
  output logic             o_s,
  output logic             o_rise,
  output logic             o_fall
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_s;
  logic [CNT_W-1:0] r_cnt;
  edge_t            r_edge;

  logic             w_match;
  logic             w_accept;

  assign w_match  = (r_sync2 == r_s);
  // Compare with >= so a threshold lowered below the running count accepts at once.
  assign w_accept = !w_match && (r_cnt >= i_thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
      r_edge  <= EDGE_NONE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_edge  <= EDGE_NONE;
      if (w_match) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_s    <= r_sync2;
        r_cnt  <= '0;
        r_edge <= edge_of(r_sync2);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_s    = r_s;
  assign o_rise = (r_edge == EDGE_RISE);
  assign o_fall = (r_edge == EDGE_FALL);

endmodule

// File: rtl/inv_bank_dgl.sv
// N-channel deglitched inverter/buffer bank; o = filtered state XOR pol, updated
// 2+thr edges after capture, with one-cycle rise/fall flags on the filtered state.
module inv_bank_dgl
  import inv_bank_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic [N_CH-1:0]  i,
  input  logic [N_CH-1:0]  pol,
  input  logic [CNT_W-1:0] thr,
  output logic [N_CH-1:0]  o,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall
);

  logic [N_CH-1:0] w_s;
  // Supply pins exist for schematic connectivity only.
  logic            w_unused_supply;

  assign w_unused_supply = ^{CELV, CELG, SUB};

  if ((N_CH < 1) || (N_CH > N_CH_MAX)) begin : g_bad_n_ch
    $error("inv_bank_dgl: N_CH out of range");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    inv_dgl_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (i[g]),
      .i_thr  (thr),
      .o_s    (w_s[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

  assign o = w_s ^ pol;

endmodule

// File: tb/tb_inv_bank_dgl.sv
// Directed bench for inv_bank_dgl with a per-cycle reference model and literal checkpoints.
module tb_inv_bank_dgl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i;
  logic [N-1:0] pol;
  logic [3:0]   thr;
  logic [N-1:0] o, rise, fall;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  inv_bank_dgl #(.N_CH(N), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .CELV (1'b1),
    .CELG (1'b0),
    .SUB  (1'b0),
    .i    (i),
    .pol  (pol),
    .thr  (thr),
    .o    (o),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  // Reference: s flips once the delayed input has disagreed with it on thr+1
  // consecutive edges; the input seen at edge k is the one sampled at edge k-2.
  logic [N-1:0] m_s = '0, m_rise = '0, m_fall = '0;
  logic [N-1:0] m_hist[$] = '{4'h0, 4'h0};
  int           m_streak[N];

  always @(posedge clk) begin
    logic [N-1:0] seen;
    if (rst) begin
      m_s = '0; m_rise = '0; m_fall = '0;
      m_hist = '{4'h0, 4'h0};
      for (int c = 0; c < N; c++) m_streak[c] = 0;
    end else begin
      seen = m_hist.pop_front();
      m_hist.push_back(i);
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < N; c++) begin
        if (seen[c] == m_s[c]) begin
          m_streak[c] = 0;
        end else if (m_streak[c] >= int'(thr)) begin
          m_s[c] = seen[c];
          if (seen[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
          m_streak[c] = 0;
        end else begin
          m_streak[c] = m_streak[c] + 1;
        end
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({o, rise, fall} !== {m_s ^ pol, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL model t=%0t o/rise/fall=%b/%b/%b want %b/%b/%b",
                 $time, o, rise, fall, m_s ^ pol, m_rise, m_fall);
      end
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    rst = 1'b1; pol = 4'b1111; i = 4'b1111; thr = 4'd3;
    tick(3);
    chk("reset_o", o, 4'b1111);
    chk("reset_rise", rise, 4'b0000);
    chk("reset_fall", fall, 4'b0000);
    rst = 1'b0;
    tick(5);
    chk("rel_pre_rise", rise, 4'b0000);
    chk("rel_pre_o", o, 4'b1111);
    tick(1);
    chk("rel_rise", rise, 4'b1111);
    chk("rel_o", o, 4'b0000);
    tick(1);
    chk("rel_rise_1cyc", rise, 4'b0000);

    // Latency on channel 0 with thr=3
    i = 4'b0000;
    tick(10);
    chk("lat_settle_o", o, 4'b1111);
    i = 4'b0001;
    tick(5);
    chk("lat_pre_o", o, 4'b1111);
    tick(1);
    chk("lat_rise", rise, 4'b0001);
    chk("lat_o", o, 4'b1110);
    chk("lat_fall", fall, 4'b0000);
    tick(1);
    chk("lat_rise_1cyc", rise, 4'b0000);

    // Glitch of 3 sampled cycles rejected, 4 accepted
    i = 4'b0011; tick(3);
    i = 4'b0001; tick(8);
    chk("glitch3_o", o, 4'b1110);
    i = 4'b0011; tick(4);
    i = 4'b0001; tick(2);
    chk("glitch4_rise", rise, 4'b0010);
    chk("glitch4_o", o, 4'b1100);
    tick(8);
    chk("glitch4_back_o", o, 4'b1110);

    // thr=0: follows on the third edge
    thr = 4'd0;
    i = 4'b0101;
    tick(2);
    chk("thr0_pre_o", o, 4'b1110);
    tick(1);
    chk("thr0_rise", rise, 4'b0100);
    chk("thr0_o", o, 4'b1010);
    tick(3);

    // thr=15: needs 16 stable cycles
    thr = 4'd15;
    i = 4'b0001;
    tick(17);
    chk("thr15_pre_fall", fall, 4'b0000);
    chk("thr15_pre_o", o, 4'b1010);
    tick(1);
    chk("thr15_fall", fall, 4'b0100);
    chk("thr15_o", o, 4'b1110);
    tick(2);

    // Lower thr from 10 to 2 with the count at 5
    thr = 4'd10;
    i = 4'b0101;
    tick(7);
    chk("thrdrop_pre_o", o, 4'b1110);
    thr = 4'd2;
    tick(1);
    chk("thrdrop_rise", rise, 4'b0100);
    chk("thrdrop_o", o, 4'b1010);
    tick(2);

    // Polarity toggle is combinational and pulse-free
    pol = 4'b1011;
    #1;
    chk("pol_o", o, 4'b1110);
    tick(1);
    chk("pol_rise", rise, 4'b0000);
    chk("pol_fall", fall, 4'b0000);

    // Simultaneous events on channels 0 and 3
    thr = 4'd3;
    i = 4'b1100;
    tick(5);
    chk("simul_pre_rise", rise, 4'b0000);
    tick(1);
    chk("simul_rise", rise, 4'b1000);
    chk("simul_fall", fall, 4'b0001);
    chk("simul_o", o, 4'b0111);
    tick(2);

    // Reset mid-count, then re-acquire from s=0
    thr = 4'd8;
    i = 4'b1101;
    tick(6);
    rst = 1'b1;
    tick(1);
    chk("rstmid_o", o, 4'b1011);
    rst = 1'b0;
    tick(10);
    chk("rstmid_pre_rise", rise, 4'b0000);
    chk("rstmid_pre_o", o, 4'b1011);
    tick(1);
    chk("rstmid_rise", rise, 4'b1101);
    chk("rstmid_o_after", o, 4'b0110);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
